// File: rtl/multicore_system_ram_scrub_master.sv
// Avalon-MM scrub master for one core's 1024x32 on-chip RAM.
// It fills a region with the pattern seed+k, reads it back and checks it,
// or does both, and logs the error count plus the first failing address and data.
module multicore_system_ram_scrub_master #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       first_err_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata
);
  localparam int LEN_W = ADDR_W + 1;
  localparam int LAST  = READ_LATENCY - 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              verify_q, verify_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       seed_q, seed_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              cs_q, cs_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LEN_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
  logic [31:0]       ferr_data_q, ferr_data_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [31:0]       rd_exp_q  [READ_LATENCY];
  logic [31:0]       rd_exp_d  [READ_LATENCY];
  logic [ADDR_W-1:0] rd_addr_q [READ_LATENCY];
  logic [ADDR_W-1:0] rd_addr_d [READ_LATENCY];
  logic [LEN_W-1:0]  idx_nxt;
  logic              is_last, inflight, mismatch;

  // Pattern word for offset k of the region.
  function automatic logic [31:0] pattern(input logic [31:0] s, input logic [LEN_W-1:0] off);
    return s + 32'(off);
  endfunction

  // Region address for offset k; wraps modulo the RAM depth.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] off);
    return b + off;
  endfunction

  // Sequencer: config capture, next state and the registered bus cycle for the next clock.
  always_comb begin
    state_d  = state_q;
    verify_d = verify_q;
    base_d   = base_q;
    len_d    = len_q;
    seed_d   = seed_q;
    idx_d    = idx_q;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    idx_nxt  = idx_q + LEN_W'(1);
    is_last  = (idx_q == len_q - LEN_W'(1));
    // Reads still travelling through the tracker, ignoring the one compared this cycle.
    inflight = 1'b0;
    for (int i = 0; i < LAST; i++) inflight = inflight | rd_vld_q[i];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          verify_d = mode[1];
          base_d   = base_addr;
          len_d    = length;
          seed_d   = seed;
          idx_d    = '0;
          if (length == '0 || mode == 2'b00) begin
            state_d = S_DONE;
          end else begin
            cs_d    = 1'b1;
            wr_d    = mode[0];
            addr_d  = base_addr;
            wdata_d = mode[0] ? seed : '0;
            state_d = mode[0] ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: begin
        if (is_last) begin
          if (verify_q) begin
            state_d = S_READ;
            idx_d   = '0;
            cs_d    = 1'b1;
            addr_d  = base_q;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d   = idx_nxt;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = word_addr(base_q, idx_nxt[ADDR_W-1:0]);
          wdata_d = pattern(seed_q, idx_nxt);
        end
      end
      S_READ: begin
        if (is_last) begin
          state_d = S_DRAIN;
        end else begin
          idx_d  = idx_nxt;
          cs_d   = 1'b1;
          addr_d = word_addr(base_q, idx_nxt[ADDR_W-1:0]);
        end
      end
      S_DRAIN: if (!inflight) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read tracker shift register and mismatch logging at its output stage.
  always_comb begin
    rd_vld_d     = (rd_vld_q << 1) | READ_LATENCY'(cs_q & ~wr_q);
    rd_exp_d[0]  = pattern(seed_q, idx_q);
    rd_addr_d[0] = addr_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_exp_d[i]  = rd_exp_q[i-1];
      rd_addr_d[i] = rd_addr_q[i-1];
    end
    mismatch    = rd_vld_q[LAST] && (avm_readdata != rd_exp_q[LAST]);
    err_cnt_d   = err_cnt_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    if (state_q == S_IDLE && start && mode[1]) begin
      err_cnt_d   = '0;
      ferr_addr_d = '0;
      ferr_data_d = '0;
    end else if (mismatch) begin
      err_cnt_d = err_cnt_q + LEN_W'(1);
      if (err_cnt_q == '0) begin
        ferr_addr_d = rd_addr_q[LAST];
        ferr_data_d = avm_readdata;
      end
    end
  end

  // Control, bus and error registers; reset forces IDLE and drops outstanding reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_cnt_q   <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      rd_vld_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_cnt_q   <= err_cnt_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  // Captured configuration and tracker payload; qualified by state and valid bits.
  always_ff @(posedge clk) begin
    verify_q  <= verify_d;
    base_q    <= base_d;
    len_q     <= len_d;
    seed_q    <= seed_d;
    rd_exp_q  <= rd_exp_d;
    rd_addr_q <= rd_addr_d;
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err_count      = err_cnt_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = {4{cs_q}};
  assign avm_chipselect = cs_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
endmodule

// File: tb/tb_multicore_system_ram_scrub_master.sv
// Scoreboard bench for the RAM scrub master: expected bus cycles and completion
// records are queued by the driver from a memory-level model, a monitor pops and compares.
module tb_multicore_system_ram_scrub_master;
  typedef struct { logic wr; logic [9:0] addr; logic [31:0] data; } bus_t;
  typedef struct { int start_cyc; int rel; logic [10:0] err; logic [9:0] fa; logic [31:0] fd; } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0, sweep_done = 0;

  logic rst, start, busy, done, a_cs, a_wr;
  logic [1:0] mode;
  logic [9:0] base, fa, a_addr;
  logic [10:0] len, err;
  logic [31:0] seed, fd, a_wd, a_rd;
  logic [3:0] a_be;

  multicore_system_ram_scrub_master #(.READ_LATENCY(1), .ADDR_W(10)) dut (
    .clk(clk), .reset(rst), .start(start), .mode(mode), .base_addr(base), .length(len),
    .seed(seed), .busy(busy), .done(done), .err_count(err), .first_err_addr(fa),
    .first_err_data(fd), .avm_address(a_addr), .avm_byteenable(a_be),
    .avm_chipselect(a_cs), .avm_write(a_wr), .avm_writedata(a_wd), .avm_readdata(a_rd));

  // RAM slave with one cycle of read latency
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (a_cs && a_wr) ram[a_addr] <= a_wd;
    if (a_cs && !a_wr) a_rd <= ram[a_addr];
  end

  // Reference model: what the RAM should hold and what the error log should say
  logic [31:0] mdl [1024];
  logic [10:0] m_err = '0;
  logic [9:0]  m_fa = '0;
  logic [31:0] m_fd = '0;
  bus_t bus_q[$];
  res_t res_q[$];
  bus_t mt;
  res_t mr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every bus cycle and every done pulse is matched against the queues
  always @(negedge clk) begin
    if (a_cs === 1'b1) begin
      if (bus_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL bus_extra actual=addr %0h wr %0b required=no bus cycle", a_addr, a_wr);
      end else begin
        mt = bus_q.pop_front();
        check("bus_wr", a_wr, mt.wr);
        check("bus_addr", a_addr, mt.addr);
        if (mt.wr) check("bus_wdata", a_wd, mt.data);
        check("bus_be", a_be, 4'hF);
      end
    end
    if (done === 1'b1) begin
      if (res_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_extra actual=done required=no done at cycle %0d", cyc);
      end else begin
        mr = res_q.pop_front();
        check("done_cycle", cyc - mr.start_cyc + 1, mr.rel);
        check("busy_at_done", busy, 1);
        check("err_count", err, mr.err);
        check("first_err_addr", fa, mr.fa);
        check("first_err_data", fd, mr.fd);
        check("bus_left_at_done", bus_q.size(), 0);
      end
    end
  end

  task automatic corrupt(input logic [9:0] a, output logic [31:0] v);
    v = mdl[a] ^ ($urandom | 32'h1);
    mdl[a] = v;
    ram[a] <= v;
  endtask

  // Predict one operation from the region rules, start it, wait for its completion
  task automatic run_op(input logic [1:0] md, input logic [9:0] b, input logic [10:0] n,
                        input logic [31:0] sd, input int poke);
    res_t r;
    logic [9:0] a;
    r.start_cyc = cyc + 1;
    if (md[1]) begin m_err = '0; m_fa = '0; m_fd = '0; end
    if (n == 0 || md == 2'b00) begin
      r.rel = 1;
    end else begin
      if (md[0])
        for (int k = 0; k < n; k++) begin
          a = b + 10'(k);
          bus_q.push_back('{1'b1, a, sd + 32'(k)});
          mdl[a] = sd + 32'(k);
        end
      if (md[1])
        for (int k = 0; k < n; k++) begin
          a = b + 10'(k);
          bus_q.push_back('{1'b0, a, 32'h0});
          if (mdl[a] != sd + 32'(k)) begin
            if (m_err == 0) begin m_fa = a; m_fd = mdl[a]; end
            m_err++;
          end
        end
      r.rel = (md[0] ? int'(n) : 0) + (md[1] ? int'(n) + 1 : 0) + 1;
    end
    r.err = m_err; r.fa = m_fa; r.fd = m_fd;
    res_q.push_back(r);
    start = 1'b1; mode = md; base = b; len = n; seed = sd;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); base = 10'($urandom); len = 11'($urandom); seed = $urandom;
    for (int i = 0; i < 2 * n + 20; i++) begin
      if (res_q.size() == 0) break;
      if (poke != 0 && (cyc - r.start_cyc + 1) == poke) begin
        start = 1'b1; mode = 2'b10; len = 11'd3;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (res_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no done required=done at cycle %0d", r.rel);
      res_q.delete(); bus_q.delete();
    end
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    logic [31:0] v1, v2;
    logic [9:0] b;
    logic [1:0] md;
    logic [10:0] n;
    rst = 1'b1; start = 1'b0; mode = '0; base = '0; len = '0; seed = '0;
    for (int i = 0; i < 1024; i++) begin ram[i] <= '0; mdl[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", a_cs, 0);
    check("rst_be", a_be, 0);
    check("rst_bus", {a_wr, a_addr, a_wd}, 0);
    check("rst_err", {err, fa, fd}, 0);

    run_op(2'b11, 10'h000, 11'd1024, 32'hA5A5_0000, 0);
    check("fill_verify_err", err, 0);
    corrupt(10'h123, v1);
    corrupt(10'h200, v2);
    run_op(2'b10, 10'h000, 11'd1024, 32'hA5A5_0000, 0);
    check("fault_err_count", err, 2);
    check("fault_first_addr", fa, 10'h123);
    check("fault_first_data", fd, v1);

    run_op(2'b00, 10'($urandom), 11'd5, $urandom, 0);
    check("noop_holds_err", err, 2);
    check("noop_holds_data", fd, v1);
    run_op(2'b11, 10'($urandom), 11'd0, $urandom, 0);
    check("zero_len_clears", err, 0);

    run_op(2'b01, 10'h3FE, 11'd4, 32'h10, 0);
    check("wrap_ram_3fe", ram[10'h3FE], 32'h10);
    check("wrap_ram_000", ram[10'h000], 32'h12);
    check("wrap_ram_001", ram[10'h001], 32'h13);

    run_op(2'b01, 10'($urandom), 11'd20, $urandom, 5);

    // Leave a nonzero error log, then reset at write 10 of 100
    b = 10'($urandom);
    corrupt(b + 10'd2, v1);
    run_op(2'b10, b, 11'd4, mdl[b] ^ 32'h1, 0);
    b = 10'($urandom); v2 = $urandom;
    for (int k = 0; k < 10; k++) begin
      bus_q.push_back('{1'b1, b + 10'(k), v2 + 32'(k)});
      mdl[b + 10'(k)] = v2 + 32'(k);
    end
    m_err = '0; m_fa = '0; m_fd = '0;
    start = 1'b1; mode = 2'b01; base = b; len = 11'd100; seed = v2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy_done", {busy, done}, 0);
    check("midrst_bus", {a_cs, a_wr, a_be, a_addr, a_wd}, 0);
    check("midrst_err", {err, fa, fd}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_writes_seen", bus_q.size(), 0);

    for (int t = 0; t < 12; t++) begin
      md = 2'($urandom);
      b = 10'($urandom);
      n = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2)) : 11'($urandom_range(1, 64));
      if ($urandom_range(0, 1) == 1) corrupt(b + 10'($urandom_range(0, 63)), v1);
      run_op(md, b, n, (md == 2'b10) ? mdl[b] - 32'($urandom_range(0, 1)) : $urandom, 0);
    end

    for (int i = 0; i < 500 && sweep_done < 2; i++) @(negedge clk);
    check("latency_sweep_finished", sweep_done, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Latency sweep instances: fill+verify 16 words, then verify with one corrupted word
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = 2 + 2 * g;
    logic rst_s, start_s, busy_s, done_s, cs_s, wr_s;
    logic [1:0] mode_s;
    logic [9:0] base_s, fa_s, addr_s;
    logic [10:0] len_s, err_s;
    logic [31:0] seed_s, fd_s, wd_s, rd_s;
    logic [3:0] be_s;
    logic [31:0] ram_s [1024];
    logic [31:0] pipe_s [L];

    multicore_system_ram_scrub_master #(.READ_LATENCY(L), .ADDR_W(10)) dut_s (
      .clk(clk), .reset(rst_s), .start(start_s), .mode(mode_s), .base_addr(base_s),
      .length(len_s), .seed(seed_s), .busy(busy_s), .done(done_s), .err_count(err_s),
      .first_err_addr(fa_s), .first_err_data(fd_s), .avm_address(addr_s),
      .avm_byteenable(be_s), .avm_chipselect(cs_s), .avm_write(wr_s),
      .avm_writedata(wd_s), .avm_readdata(rd_s));

    always @(posedge clk) begin
      if (cs_s && wr_s) ram_s[addr_s] <= wd_s;
      if (cs_s && !wr_s) pipe_s[0] <= ram_s[addr_s];
      for (int i = 1; i < L; i++) pipe_s[i] <= pipe_s[i-1];
    end
    assign rd_s = pipe_s[L-1];

    initial begin
      int s, rel, bad_cnt, off;
      logic [31:0] sd, v;
      logic [9:0] b;
      rst_s = 1'b1; start_s = 1'b0; mode_s = '0; base_s = '0; len_s = '0; seed_s = '0;
      for (int i = 0; i < 1024; i++) ram_s[i] <= '0;
      repeat (3) @(negedge clk);
      rst_s = 1'b0;
      @(negedge clk);
      b = 10'($urandom); sd = $urandom;
      off = $urandom_range(3, 12); v = (sd + 32'(off)) ^ 32'h0100_0001;
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 1) ram_s[b + 10'(off)] <= v;
        start_s = 1'b1; mode_s = (ph == 0) ? 2'b11 : 2'b10;
        base_s = b; len_s = 11'd16; seed_s = sd; s = cyc + 1;
        @(negedge clk);
        start_s = 1'b0;
        rel = 0;
        for (int i = 0; i < 200; i++) begin
          if (done_s) begin rel = cyc - s + 1; break; end
          @(negedge clk);
        end
        if (ph == 0) begin
          check($sformatf("lat%0d_fill_verify_done", L), rel, 2 * 16 + L + 1);
          check($sformatf("lat%0d_fill_verify_err", L), err_s, 0);
          bad_cnt = 0;
          for (int k = 0; k < 16; k++) if (ram_s[b + 10'(k)] !== sd + 32'(k)) bad_cnt++;
          check($sformatf("lat%0d_ram_contents_bad", L), bad_cnt, 0);
        end else begin
          check($sformatf("lat%0d_verify_done", L), rel, 16 + L + 1);
          check($sformatf("lat%0d_verify_err", L), err_s, 1);
          check($sformatf("lat%0d_first_addr", L), fa_s, b + 10'(off));
          check($sformatf("lat%0d_first_data", L), fd_s, v);
        end
        repeat (2) @(negedge clk);
      end
      sweep_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
